// File: rtl/mmc1_sync_mapper.sv
// ============================================================================
// Module   : mmc1_sync_mapper
// Purpose  : Fully synchronous MMC1-style bank controller. The CPU bus is
//            oversampled on SYS_CLK and fed to a counted serial loader.
//            Optional macro: MMC1_CONSEC_WRITE_FILTER_EN (drops RMW 2nd write)
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mmc1_sync_mapper #(
  parameter int SHIFT_LEN   = 5,
  parameter int PRG_BANK_W  = 4,
  parameter int CHR_BANK_W  = 5,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  SYS_CLK,
  input  logic                  SYS_RST,
  input  logic                  CPU_M2,
  input  logic                  CPU_A13,
  input  logic                  CPU_A14,
  input  logic                  nCPU_ROMSEL,
  input  logic                  nCPU_RW,
  input  logic                  CPU_D0,
  input  logic                  CPU_D7,
  input  logic                  PPU_A10,
  input  logic                  PPU_A11,
  input  logic                  PPU_A12,
  output logic [PRG_BANK_W-1:0] PRG_A,
  output logic [CHR_BANK_W-1:0] CHR_A,
  output logic                  CIRAM_A10,
  output logic                  nPRG_CE,
  output logic                  nWRAM_CE
);

  localparam int             c_CNT_W = $clog2(SHIFT_LEN);
  localparam logic [c_CNT_W-1:0] c_LAST = c_CNT_W'(SHIFT_LEN - 1);

  // Synchroniser lane layout: {D7, D0, RW, ROMSEL, A14, A13, M2}
  logic [6:0]                   w_pins;
  logic [SYNC_STAGES-1:0][6:0]  r_sync;
  logic [6:0]                   w_sync;
  logic                         w_m2;
  logic                         r_m2_prev;
  logic                         w_strobe;

  // Captured sample: {D7, D0, RW, ROMSEL, A14, A13}
  logic [5:0]                   r_cap;
  logic                         w_write;
  logic                         w_filtered;

  // The top shift bit is never loaded: the final bit comes straight from D0.
  logic [SHIFT_LEN-2:0]         r_sr;
  logic [c_CNT_W-1:0]           r_cnt;
  logic [SHIFT_LEN-1:0]         w_value;

  logic [4:0]                   r_ctrl;
  logic [PRG_BANK_W:0]          r_prg;
  logic [CHR_BANK_W-1:0]        r_chr0;
  logic [CHR_BANK_W-1:0]        r_chr1;

  assign w_pins   = {CPU_D7, CPU_D0, nCPU_RW, nCPU_ROMSEL, CPU_A14, CPU_A13, CPU_M2};
  assign w_sync   = r_sync[SYNC_STAGES-1];
  assign w_m2     = w_sync[0];
  assign w_strobe = r_m2_prev & ~w_m2;
  assign w_write  = ~r_cap[2] & ~r_cap[3];
  assign w_value  = {r_cap[4], r_sr};

`ifdef MMC1_CONSEC_WRITE_FILTER_EN
  logic r_prev_wr;
  assign w_filtered = r_prev_wr;
`else
  assign w_filtered = 1'b0;
`endif

  always_ff @(posedge SYS_CLK) begin
    if (SYS_RST) begin
      r_sync    <= '0;
      r_m2_prev <= 1'b0;
      r_cap     <= '0;
      r_sr      <= '0;
      r_cnt     <= '0;
      r_ctrl    <= 5'b01100;
      r_prg     <= '0;
      r_chr0    <= '0;
      r_chr1    <= '0;
`ifdef MMC1_CONSEC_WRITE_FILTER_EN
      r_prev_wr <= 1'b0;
`endif
    end else begin
      r_sync    <= {r_sync[SYNC_STAGES-2:0], w_pins};
      r_m2_prev <= w_m2;
      if (w_m2) begin
        r_cap <= w_sync[6:1];
      end
      if (w_strobe) begin
`ifdef MMC1_CONSEC_WRITE_FILTER_EN
        r_prev_wr <= w_write;
`endif
        if (w_write) begin
          if (r_cap[5]) begin
            r_sr        <= '0;
            r_cnt       <= '0;
            r_ctrl[3:2] <= 2'b11;
          end else if (!w_filtered) begin
            if (r_cnt != c_LAST) begin
              for (int i = 0; i < SHIFT_LEN - 1; i++) begin
                if (r_cnt == c_CNT_W'(i)) begin
                  r_sr[i] <= r_cap[4];
                end
              end
              r_cnt <= r_cnt + c_CNT_W'(1);
            end else begin
              case (r_cap[1:0])
                2'b00:   r_ctrl <= w_value[4:0];
                2'b01:   r_chr0 <= w_value[CHR_BANK_W-1:0];
                2'b10:   r_chr1 <= w_value[CHR_BANK_W-1:0];
                default: r_prg  <= w_value[PRG_BANK_W:0];
              endcase
              r_sr  <= '0;
              r_cnt <= '0;
            end
          end
        end
      end
    end
  end

  // Registered bank state combined with live address pins.
  always_comb begin
    PRG_A = r_prg[PRG_BANK_W-1:0];
    case (r_ctrl[3:2])
      2'b10:   PRG_A = CPU_A14 ? r_prg[PRG_BANK_W-1:0] : '0;
      2'b11:   PRG_A = CPU_A14 ? '1 : r_prg[PRG_BANK_W-1:0];
      default: PRG_A[0] = CPU_A14;
    endcase

    CHR_A = r_chr0;
    if (r_ctrl[4]) begin
      CHR_A = PPU_A12 ? r_chr1 : r_chr0;
    end else begin
      CHR_A[0] = PPU_A12;
    end

    case (r_ctrl[1:0])
      2'b00:   CIRAM_A10 = 1'b0;
      2'b01:   CIRAM_A10 = 1'b1;
      2'b10:   CIRAM_A10 = PPU_A10;
      default: CIRAM_A10 = PPU_A11;
    endcase
  end

  assign nPRG_CE  = nCPU_ROMSEL | ~nCPU_RW;
  assign nWRAM_CE = ~(nCPU_ROMSEL & ~r_prg[PRG_BANK_W] & CPU_A14 & CPU_A13);

endmodule

`default_nettype wire

// File: tb/tb_mmc1_sync_mapper.sv
// ============================================================================
// Module   : tb_mmc1_sync_mapper
// Purpose  : Randomised self-checking bench for mmc1_sync_mapper against a
//            bit-queue reference model (honours MMC1_CONSEC_WRITE_FILTER_EN).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mmc1_sync_mapper;

  localparam int SL = 5;
  localparam int PW = 4;
  localparam int CW = 5;
  localparam int OW = PW + CW + 3;
`ifdef MMC1_CONSEC_WRITE_FILTER_EN
  localparam bit FILT = 1'b1;
`else
  localparam bit FILT = 1'b0;
`endif

  logic SYS_CLK = 1'b0;
  logic SYS_RST = 1'b1;
  logic CPU_M2 = 1'b0, CPU_A13 = 1'b0, CPU_A14 = 1'b0;
  logic nCPU_ROMSEL = 1'b1, nCPU_RW = 1'b1, CPU_D0 = 1'b0, CPU_D7 = 1'b0;
  logic PPU_A10 = 1'b0, PPU_A11 = 1'b0, PPU_A12 = 1'b0;
  logic [PW-1:0] PRG_A;
  logic [CW-1:0] CHR_A;
  logic CIRAM_A10, nPRG_CE, nWRAM_CE;

  int errors = 0;
  int checks = 0;

  // Reference model state
  int m_ctrl, m_prg, m_chr0, m_chr1;
  bit m_prev_wr;
  int bitsq[$];

  mmc1_sync_mapper #(.SHIFT_LEN(SL), .PRG_BANK_W(PW), .CHR_BANK_W(CW), .SYNC_STAGES(2)) dut (
    .SYS_CLK(SYS_CLK), .SYS_RST(SYS_RST), .CPU_M2(CPU_M2), .CPU_A13(CPU_A13),
    .CPU_A14(CPU_A14), .nCPU_ROMSEL(nCPU_ROMSEL), .nCPU_RW(nCPU_RW),
    .CPU_D0(CPU_D0), .CPU_D7(CPU_D7), .PPU_A10(PPU_A10), .PPU_A11(PPU_A11),
    .PPU_A12(PPU_A12), .PRG_A(PRG_A), .CHR_A(CHR_A), .CIRAM_A10(CIRAM_A10),
    .nPRG_CE(nPRG_CE), .nWRAM_CE(nWRAM_CE)
  );

  always #5 SYS_CLK = ~SYS_CLK;

  function automatic void model_reset();
    m_ctrl = 12; m_prg = 0; m_chr0 = 0; m_chr1 = 0; m_prev_wr = 1'b0;
    bitsq.delete();
  endfunction

  function automatic void model_cycle(bit romsel, bit rw, bit a14, bit a13, bit d0, bit d7);
    bit wr = !romsel && !rw;
    int v;
    if (wr) begin
      if (d7) begin
        bitsq.delete();
        m_ctrl = m_ctrl | 12;
      end else if (!(FILT && m_prev_wr)) begin
        bitsq.push_back(int'(d0));
        if (bitsq.size() == SL) begin
          v = 0;
          for (int i = 0; i < SL; i++) v += bitsq[i] << i;
          case ({a14, a13})
            2'b00:   m_ctrl = v % 32;
            2'b01:   m_chr0 = v % (1 << CW);
            2'b10:   m_chr1 = v % (1 << CW);
            default: m_prg  = v % (1 << (PW + 1));
          endcase
          bitsq.delete();
        end
      end
    end
    m_prev_wr = wr;
  endfunction

  function automatic logic [OW-1:0] exp_outs(logic [6:0] k);
    bit a14 = k[6], a13 = k[5], a12 = k[4], a11 = k[3], a10 = k[2];
    bit romsel = k[1], rw = k[0];
    int lo = m_prg % (1 << PW);
    int wdis = (m_prg >> PW) & 1;
    int p, c, ci;
    case ((m_ctrl >> 2) & 3)
      2:       p = a14 ? lo : 0;
      3:       p = a14 ? (1 << PW) - 1 : lo;
      default: p = (lo / 2) * 2 + int'(a14);
    endcase
    if ((m_ctrl >> 4) & 1) c = a12 ? m_chr1 : m_chr0;
    else                   c = (m_chr0 / 2) * 2 + int'(a12);
    case (m_ctrl & 3)
      0:       ci = 0;
      1:       ci = 1;
      2:       ci = int'(a10);
      default: ci = int'(a11);
    endcase
    return {PW'(p), CW'(c), ci[0], romsel | !rw,
            !(romsel && wdis == 0 && a14 && a13)};
  endfunction

  task automatic cpu_cycle(input bit romsel, input bit rw, input bit a14,
                           input bit a13, input bit d0, input bit d7);
    @(negedge SYS_CLK);
    nCPU_ROMSEL = romsel; nCPU_RW = rw; CPU_A14 = a14; CPU_A13 = a13;
    CPU_D0 = d0; CPU_D7 = d7; CPU_M2 = 1'b1;
    repeat (6) @(negedge SYS_CLK);
    CPU_M2 = 1'b0;
    repeat (6) @(negedge SYS_CLK);
    model_cycle(romsel, rw, a14, a13, d0, d7);
  endtask

  task automatic wr(input bit a14, input bit a13, input bit d0, input bit d7);
    cpu_cycle(1'b0, 1'b0, a14, a13, d0, d7);
  endtask

  task automatic idle();
    cpu_cycle(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic load(input bit a14, input bit a13, input int v);
    for (int i = 0; i < SL; i++) begin
      wr(a14, a13, v[i], 1'b0);
      idle();
    end
  endtask

  task automatic test_reset();
    logic [OW-1:0] got, exp;
    SYS_RST = 1'b1;
    repeat (4) @(negedge SYS_CLK);
    SYS_RST = 1'b0;
    model_reset();
    for (int k = 0; k < 128; k++) begin
      @(negedge SYS_CLK);
      {CPU_A14, CPU_A13, PPU_A12, PPU_A11, PPU_A10, nCPU_ROMSEL, nCPU_RW} = 7'(k);
      #1;
      got = {PRG_A, CHR_A, CIRAM_A10, nPRG_CE, nWRAM_CE};
      exp = exp_outs(7'(k));
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL reset k=%0d got=%h exp=%h", k, got, exp);
      end
    end
  endtask

  task automatic test_prg_load();
    logic [OW-1:0] got, exp;
    load(1'b1, 1'b1, 5'b00101);
    for (int k = 0; k < 128; k++) begin
      @(negedge SYS_CLK);
      {CPU_A14, CPU_A13, PPU_A12, PPU_A11, PPU_A10, nCPU_ROMSEL, nCPU_RW} = 7'(k);
      #1;
      got = {PRG_A, CHR_A, CIRAM_A10, nPRG_CE, nWRAM_CE};
      exp = exp_outs(7'(k));
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL prg_load k=%0d got=%h exp=%h", k, got, exp);
      end
    end
  endtask

  task automatic test_loader_reset();
    logic [OW-1:0] got, exp;
    load(1'b0, 1'b0, 5'b00011);
    for (int i = 0; i < 3; i++) begin wr(1'b0, 1'b1, 1'b1, 1'b0); idle(); end
    wr(1'b0, 1'b1, 1'b0, 1'b1); idle();
    load(1'b0, 1'b1, 0);
    for (int i = 0; i < 4; i++) begin wr(1'b1, 1'b0, 1'b1, 1'b0); idle(); end
    wr(1'b1, 1'b0, 1'b1, 1'b1); idle();
    for (int k = 0; k < 128; k++) begin
      @(negedge SYS_CLK);
      {CPU_A14, CPU_A13, PPU_A12, PPU_A11, PPU_A10, nCPU_ROMSEL, nCPU_RW} = 7'(k);
      #1;
      got = {PRG_A, CHR_A, CIRAM_A10, nPRG_CE, nWRAM_CE};
      exp = exp_outs(7'(k));
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL loader_reset k=%0d got=%h exp=%h", k, got, exp);
      end
    end
  endtask

  task automatic test_chr_mirror();
    logic [OW-1:0] got, exp;
    load(1'b0, 1'b0, 5'b10010);
    load(1'b0, 1'b1, 3);
    load(1'b1, 1'b0, 9);
    for (int k = 0; k < 128; k++) begin
      @(negedge SYS_CLK);
      {CPU_A14, CPU_A13, PPU_A12, PPU_A11, PPU_A10, nCPU_ROMSEL, nCPU_RW} = 7'(k);
      #1;
      got = {PRG_A, CHR_A, CIRAM_A10, nPRG_CE, nWRAM_CE};
      exp = exp_outs(7'(k));
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL chr_mirror k=%0d got=%h exp=%h", k, got, exp);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [OW-1:0] got, exp;
    wr(1'b0, 1'b0, 1'b0, 1'b1); idle();
    wr(1'b0, 1'b0, 1'b1, 1'b0);
    wr(1'b0, 1'b0, 1'b0, 1'b0);
    idle();
    wr(1'b0, 1'b0, 1'b0, 1'b0); idle();
    wr(1'b0, 1'b0, 1'b0, 1'b0); idle();
    wr(1'b0, 1'b0, 1'b1, 1'b0); idle();
    for (int pass = 0; pass < 2; pass++) begin
      for (int k = 0; k < 128; k++) begin
        @(negedge SYS_CLK);
        {CPU_A14, CPU_A13, PPU_A12, PPU_A11, PPU_A10, nCPU_ROMSEL, nCPU_RW} = 7'(k);
        #1;
        got = {PRG_A, CHR_A, CIRAM_A10, nPRG_CE, nWRAM_CE};
        exp = exp_outs(7'(k));
        checks++;
        if (got !== exp) begin
          errors++;
          $display("FAIL back_to_back p%0d k=%0d got=%h exp=%h", pass, k, got, exp);
        end
      end
      wr(1'b0, 1'b0, 1'b1, 1'b0); idle();
    end
  endtask

  task automatic test_reset_midword();
    logic [OW-1:0] got, exp;
    wr(1'b1, 1'b1, 1'b1, 1'b0); idle();
    wr(1'b1, 1'b1, 1'b1, 1'b0); idle();
    @(negedge SYS_CLK);
    SYS_RST = 1'b1;
    @(negedge SYS_CLK);
    SYS_RST = 1'b0;
    model_reset();
    for (int pass = 0; pass < 2; pass++) begin
      for (int k = 0; k < 128; k++) begin
        @(negedge SYS_CLK);
        {CPU_A14, CPU_A13, PPU_A12, PPU_A11, PPU_A10, nCPU_ROMSEL, nCPU_RW} = 7'(k);
        #1;
        got = {PRG_A, CHR_A, CIRAM_A10, nPRG_CE, nWRAM_CE};
        exp = exp_outs(7'(k));
        checks++;
        if (got !== exp) begin
          errors++;
          $display("FAIL reset_midword p%0d k=%0d got=%h exp=%h", pass, k, got, exp);
        end
      end
      load(1'b1, 1'b1, 5'b01010);
    end
  endtask

  task automatic test_random();
    logic [OW-1:0] got, exp;
    int kind;
    for (int blk = 0; blk < 8; blk++) begin
      for (int n = 0; n < 25; n++) begin
        kind = int'($urandom_range(0, 4));
        cpu_cycle(kind == 0 ? 1'b1 : 1'b0, kind == 1 ? 1'b1 : 1'b0,
                  1'($urandom), 1'($urandom), 1'($urandom),
                  $urandom_range(0, 11) == 0);
      end
      for (int j = 0; j < 24; j++) begin
        logic [6:0] kv = 7'($urandom);
        @(negedge SYS_CLK);
        {CPU_A14, CPU_A13, PPU_A12, PPU_A11, PPU_A10, nCPU_ROMSEL, nCPU_RW} = kv;
        #1;
        got = {PRG_A, CHR_A, CIRAM_A10, nPRG_CE, nWRAM_CE};
        exp = exp_outs(kv);
        checks++;
        if (got !== exp) begin
          errors++;
          $display("FAIL random b%0d k=%h got=%h exp=%h", blk, kv, got, exp);
        end
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_prg_load();
    test_loader_reset();
    test_chr_mirror();
    test_back_to_back();
    test_reset_midword();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
